branch_resolve_station: RTL and testbench

BRANCH_RESOLVE_STATION -- requirements
Module: branch_resolve_station

---
 rtl/branch_resolve_station.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_branch_resolve_station.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_station.sv
// -----------------------------------------------------------------------------
// branch_resolve_station
//
// In-order reservation station for MIPS-style control-transfer instructions.
// Branches are dispatched with operand values or producer tags. They wait in a
// FIFO, snoop the common data bus for missing operands, and resolve one at a
// time from the head. A resolution is registered, so it is visible one cycle
// after the head becomes ready.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   flush               : empties the station and kills a resolution in flight
//   disp_valid/ready    : dispatch handshake
//   disp_inst/pc/pred_target, disp_rs/rt_val, disp_rs/rt_tag : dispatched entry
//   cdb_valid/tag/data  : result broadcast; tag 0 never names a producer
//   res_valid           : one-cycle pulse per resolved branch
//   res_pc/target/link  : branch address, resolved next pc, pc+8
//   res_taken/mispredict/illegal/link_we : resolution flags
//   count               : occupied entries
// -----------------------------------------------------------------------------
module branch_resolve_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [31:0]              disp_inst,
  input  logic [31:0]              disp_pc,
  input  logic [31:0]              disp_pred_target,
  input  logic [31:0]              disp_rs_val,
  input  logic [31:0]              disp_rt_val,
  input  logic [TAG_W-1:0]         disp_rs_tag,
  input  logic [TAG_W-1:0]         disp_rt_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [31:0]              cdb_data,
  output logic                     res_valid,
  output logic [31:0]              res_pc,
  output logic [31:0]              res_target,
  output logic [31:0]              res_link,
  output logic                     res_taken,
  output logic                     res_mispredict,
  output logic                     res_illegal,
  output logic                     res_link_we,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;

  typedef struct packed {
    logic             valid;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [31:0]      pred;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic [TAG_W-1:0] rs_tag;
    logic [TAG_W-1:0] rt_tag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_pc_q, res_pc_d, res_target_q, res_target_d, res_link_q, res_link_d;
  logic        res_taken_q, res_taken_d, res_mispredict_q, res_mispredict_d;
  logic        res_illegal_q, res_illegal_d, res_link_we_q, res_link_we_d;

  // ---------------------------------------------------------------------------
  // Head decode and evaluation
  // ---------------------------------------------------------------------------
  entry_t      head;
  logic [5:0]  opcode, funct;
  logic [4:0]  rt_field;
  logic [31:0] seq_tgt, br_tgt, jmp_tgt;
  logic        need_rs, need_rt, is_cond, cond;
  logic        h_illegal, h_taken, h_link_we, h_mispredict;
  logic [31:0] h_target;
  logic        head_ready, do_resolve;

  // NOTE: every signal written in an always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head      = ent_q[head_q];
    opcode    = head.inst[31:26];
    rt_field  = head.inst[20:16];
    funct     = head.inst[5:0];
    seq_tgt   = head.pc + 32'd8;
    br_tgt    = head.pc + 32'd4 + {{14{head.inst[15]}}, head.inst[15:0], 2'b00};
    jmp_tgt   = {head.pc[31:28], head.inst[25:0], 2'b00};
    need_rs   = 1'b0;
    need_rt   = 1'b0;
    is_cond   = 1'b0;
    cond      = 1'b0;
    h_illegal = 1'b0;
    h_taken   = 1'b0;
    h_link_we = 1'b0;
    h_target  = seq_tgt;

    case (opcode)
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          need_rs  = 1'b1;
          h_taken  = 1'b1;
          h_target = head.rs_val;
        end else begin
          h_illegal = 1'b1;
        end
      end
      OP_REGIMM: begin
        if (rt_field == RT_BLTZ) begin
          need_rs = 1'b1;
          is_cond = 1'b1;
          cond    = $signed(head.rs_val) < 32'sd0;
        end else if (rt_field == RT_BGEZ) begin
          need_rs = 1'b1;
          is_cond = 1'b1;
          cond    = $signed(head.rs_val) >= 32'sd0;
        end else begin
          h_illegal = 1'b1;
        end
      end
      OP_J: begin
        h_taken  = 1'b1;
        h_target = jmp_tgt;
      end
      OP_JAL: begin
        h_taken   = 1'b1;
        h_target  = jmp_tgt;
        h_link_we = 1'b1;
      end
      OP_BEQ: begin
        need_rs = 1'b1;
        need_rt = 1'b1;
        is_cond = 1'b1;
        cond    = head.rs_val == head.rt_val;
      end
      OP_BNE: begin
        need_rs = 1'b1;
        need_rt = 1'b1;
        is_cond = 1'b1;
        cond    = head.rs_val != head.rt_val;
      end
      OP_BLEZ: begin
        need_rs = 1'b1;
        is_cond = 1'b1;
        cond    = $signed(head.rs_val) <= 32'sd0;
      end
      OP_BGTZ: begin
        need_rs = 1'b1;
        is_cond = 1'b1;
        cond    = $signed(head.rs_val) > 32'sd0;
      end
      default: h_illegal = 1'b1;
    endcase

    if (is_cond) begin
      h_taken  = cond;
      h_target = cond ? br_tgt : seq_tgt;
    end

    // Illegal encodings need no operands and always redirect the front end.
    head_ready   = (!need_rs || head.rs_tag == '0) && (!need_rt || head.rt_tag == '0);
    do_resolve   = head.valid && head_ready;
    h_mispredict = h_illegal || (h_target != head.pred);
  end

  // ---------------------------------------------------------------------------
  // Next-state: CDB snoop, resolve/pop, dispatch/push, squash
  // ---------------------------------------------------------------------------
  logic   disp_fire;
  entry_t new_ent;

  assign disp_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;

  always_comb begin
    ent_d            = ent_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q + {{PTR_W{1'b0}}, disp_fire} - {{PTR_W{1'b0}}, do_resolve};
    res_valid_d      = 1'b0;
    res_pc_d         = res_pc_q;
    res_target_d     = res_target_q;
    res_link_d       = res_link_q;
    res_taken_d      = res_taken_q;
    res_mispredict_d = res_mispredict_q;
    res_illegal_d    = res_illegal_q;
    res_link_we_d    = res_link_we_q;

    // Tag 0 means "ready", so a broadcast on tag 0 must never match.
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && cdb_valid && cdb_tag != '0) begin
        if (ent_q[i].rs_tag == cdb_tag) begin
          ent_d[i].rs_val = cdb_data;
          ent_d[i].rs_tag = '0;
        end
        if (ent_q[i].rt_tag == cdb_tag) begin
          ent_d[i].rt_val = cdb_data;
          ent_d[i].rt_tag = '0;
        end
      end
    end

    // Operands that appear on the CDB in the same cycle as their dispatch.
    new_ent        = '{valid: 1'b1, inst: disp_inst, pc: disp_pc, pred: disp_pred_target,
                       rs_val: disp_rs_val, rt_val: disp_rt_val,
                       rs_tag: disp_rs_tag, rt_tag: disp_rt_tag};
    if (cdb_valid && disp_rs_tag != '0 && disp_rs_tag == cdb_tag) begin
      new_ent.rs_val = cdb_data;
      new_ent.rs_tag = '0;
    end
    if (cdb_valid && disp_rt_tag != '0 && disp_rt_tag == cdb_tag) begin
      new_ent.rt_val = cdb_data;
      new_ent.rt_tag = '0;
    end

    if (do_resolve) begin
      res_valid_d          = 1'b1;
      res_pc_d             = head.pc;
      res_target_d         = h_target;
      res_link_d           = seq_tgt;
      res_taken_d          = h_taken;
      res_mispredict_d     = h_mispredict;
      res_illegal_d        = h_illegal;
      res_link_we_d        = h_link_we;
      ent_d[head_q].valid  = 1'b0;
      head_d               = head_q + PTR_W'(1);
    end

    // The tail slot is always free when disp_ready is high, so it never
    // collides with the snoop writes above.
    if (disp_fire) begin
      ent_d[tail_q] = new_ent;
      tail_d        = tail_q + PTR_W'(1);
    end

    // A mispredicting resolution (or a flush) squashes everything younger,
    // including a dispatch accepted in the same cycle.
    if ((do_resolve && h_mispredict) || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    if (flush) res_valid_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      res_valid_q      <= 1'b0;
      res_pc_q         <= '0;
      res_target_q     <= '0;
      res_link_q       <= '0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_illegal_q    <= 1'b0;
      res_link_we_q    <= 1'b0;
      // NOTE: only the valid bits are reset; entry payload is meaningless
      // while invalid, so the storage array needs no reset.
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      res_valid_q      <= res_valid_d;
      res_pc_q         <= res_pc_d;
      res_target_q     <= res_target_d;
      res_link_q       <= res_link_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_illegal_q    <= res_illegal_d;
      res_link_we_q    <= res_link_we_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign res_valid      = res_valid_q;
  assign res_pc         = res_pc_q;
  assign res_target     = res_target_q;
  assign res_link       = res_link_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_illegal    = res_illegal_q;
  assign res_link_we    = res_link_we_q;
  assign count          = count_q;

endmodule

// File: tb/tb_branch_resolve_station.sv
// -----------------------------------------------------------------------------
// Self-checking bench for branch_resolve_station. A queue-based model predicts
// outputs cycle by cycle. Directed scenarios pin the model with literal values,
// then a randomized phase exercises the station against the model.
// -----------------------------------------------------------------------------
module tb_branch_resolve_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset, flush, disp_valid, disp_ready;
  logic [31:0]      disp_inst, disp_pc, disp_pred_target, disp_rs_val, disp_rt_val;
  logic [TAG_W-1:0] disp_rs_tag, disp_rt_tag, cdb_tag;
  logic             cdb_valid;
  logic [31:0]      cdb_data;
  logic             res_valid, res_taken, res_mispredict, res_illegal, res_link_we;
  logic [31:0]      res_pc, res_target, res_link;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  branch_resolve_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst(disp_inst), .disp_pc(disp_pc), .disp_pred_target(disp_pred_target),
    .disp_rs_val(disp_rs_val), .disp_rt_val(disp_rt_val),
    .disp_rs_tag(disp_rs_tag), .disp_rt_tag(disp_rt_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_pc(res_pc), .res_target(res_target), .res_link(res_link),
    .res_taken(res_taken), .res_mispredict(res_mispredict), .res_illegal(res_illegal),
    .res_link_we(res_link_we), .count(count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BLTZ, K_BGEZ, K_BAD} kind_e;

  typedef struct {
    logic [31:0]      inst, pc, pred, rs, rt;
    logic [TAG_W-1:0] rs_tag, rt_tag;
  } m_ent_t;

  typedef struct {
    logic [31:0] target, link;
    logic        taken, mis, illegal, link_we;
  } m_res_t;

  m_ent_t mq[$];

  logic        e_valid;
  logic [31:0] e_pc, e_target, e_link;
  logic        e_taken, e_mis, e_ill, e_lwe;

  function automatic kind_e kind_of(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (op == 6'd2) return K_J;
    if (op == 6'd3) return K_JAL;
    if (op == 6'd4) return K_BEQ;
    if (op == 6'd5) return K_BNE;
    if (op == 6'd6) return K_BLEZ;
    if (op == 6'd7) return K_BGTZ;
    if (op == 6'd0 && inst[5:0] == 6'd8) return K_JR;
    if (op == 6'd1 && inst[20:16] == 5'd0) return K_BLTZ;
    if (op == 6'd1 && inst[20:16] == 5'd1) return K_BGEZ;
    return K_BAD;
  endfunction

  function automatic logic is_ready(input m_ent_t e);
    kind_e k;
    logic  rs_need, rt_need;
    k = kind_of(e.inst);
    rt_need = (k == K_BEQ) || (k == K_BNE);
    rs_need = !(k == K_J || k == K_JAL || k == K_BAD);
    return (!rs_need || e.rs_tag == 0) && (!rt_need || e.rt_tag == 0);
  endfunction

  function automatic m_res_t evaluate(input m_ent_t e);
    m_res_t             r;
    kind_e              k;
    logic signed [31:0] a, b;
    logic [31:0]        off;
    logic               c;
    k   = kind_of(e.inst);
    a   = e.rs;
    b   = e.rt;
    off = {{14{e.inst[15]}}, e.inst[15:0], 2'b00};
    r.link    = e.pc + 8;
    r.link_we = (k == K_JAL);
    r.illegal = (k == K_BAD);
    r.taken   = 1'b0;
    r.target  = e.pc + 8;
    c         = 1'b0;
    case (k)
      K_J, K_JAL: begin r.taken = 1'b1; r.target = {e.pc[31:28], e.inst[25:0], 2'b00}; end
      K_JR:       begin r.taken = 1'b1; r.target = e.rs; end
      K_BAD:      ;
      default: begin
        case (k)
          K_BEQ:   c = (a == b);
          K_BNE:   c = (a != b);
          K_BLEZ:  c = (a <= 0);
          K_BGTZ:  c = (a > 0);
          K_BLTZ:  c = (a < 0);
          default: c = (a >= 0);
        endcase
        r.taken = c;
        if (c) r.target = e.pc + 4 + off;
      end
    endcase
    r.mis = r.illegal || (r.target != e.pred);
    return r;
  endfunction

  // One clock cycle: predict from current inputs, clock, compare.
  task automatic step();
    logic   exp_rdy, fire, rfire;
    m_ent_t n;
    m_res_t r;
    #1;
    exp_rdy = (mq.size() < DEPTH) && !flush;
    if (!reset) check("disp_ready", disp_ready, exp_rdy);
    if (reset) begin
      mq.delete();
      e_valid = 0; e_pc = 0; e_target = 0; e_link = 0;
      e_taken = 0; e_mis = 0; e_ill = 0; e_lwe = 0;
    end else begin
      fire    = disp_valid && exp_rdy;
      rfire   = (mq.size() > 0) && is_ready(mq[0]);
      e_valid = 1'b0;
      if (rfire) begin
        r = evaluate(mq[0]);
        e_valid = 1'b1; e_pc = mq[0].pc; e_target = r.target; e_link = r.link;
        e_taken = r.taken; e_mis = r.mis; e_ill = r.illegal; e_lwe = r.link_we;
        void'(mq.pop_front());
      end
      foreach (mq[i]) begin
        if (cdb_valid && cdb_tag != 0) begin
          if (mq[i].rs_tag == cdb_tag) begin mq[i].rs = cdb_data; mq[i].rs_tag = 0; end
          if (mq[i].rt_tag == cdb_tag) begin mq[i].rt = cdb_data; mq[i].rt_tag = 0; end
        end
      end
      if (fire) begin
        n.inst = disp_inst; n.pc = disp_pc; n.pred = disp_pred_target;
        n.rs = disp_rs_val; n.rt = disp_rt_val;
        n.rs_tag = disp_rs_tag; n.rt_tag = disp_rt_tag;
        if (cdb_valid && n.rs_tag != 0 && n.rs_tag == cdb_tag) begin n.rs = cdb_data; n.rs_tag = 0; end
        if (cdb_valid && n.rt_tag != 0 && n.rt_tag == cdb_tag) begin n.rt = cdb_data; n.rt_tag = 0; end
        mq.push_back(n);
      end
      if (rfire && e_mis) mq.delete();
      if (flush) begin mq.delete(); e_valid = 1'b0; end
    end
    @(posedge clk);
    #1;
    check("res_valid", res_valid, e_valid);
    check("count", count, mq.size());
    if (e_valid) begin
      check("res_pc", res_pc, e_pc);
      check("res_target", res_target, e_target);
      check("res_link", res_link, e_link);
      check("res_taken", res_taken, e_taken);
      check("res_mispredict", res_mispredict, e_mis);
      check("res_illegal", res_illegal, e_ill);
      check("res_link_we", res_link_we, e_lwe);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; flush = 0; disp_valid = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic disp(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pred,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [TAG_W-1:0] rs_t, input logic [TAG_W-1:0] rt_t);
    disp_valid = 1; disp_inst = inst; disp_pc = pc; disp_pred_target = pred;
    disp_rs_val = rs; disp_rt_val = rt; disp_rs_tag = rs_t; disp_rt_tag = rt_t;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 10))
      0:  i[31:26] = 6'd2;
      1:  i[31:26] = 6'd3;
      2:  begin i[31:26] = 6'd0; i[5:0] = 6'd8; end
      3:  i[31:26] = 6'd4;
      4:  i[31:26] = 6'd5;
      5:  i[31:26] = 6'd6;
      6:  i[31:26] = 6'd7;
      7:  begin i[31:26] = 6'd1; i[20:16] = 5'($urandom_range(0, 1)); end
      8:  begin i[31:26] = 6'd1; i[20:16] = 5'($urandom_range(2, 31)); end
      9:  begin i[31:26] = 6'd0; i[5:0] = 6'd9; end
      default: i[31:26] = 6'h3F;
    endcase
    return i;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ri, rpc, rs, rt, pred, raw;
    logic [TAG_W-1:0] ts, tt;
    idle();
    disp_inst = 0; disp_pc = 0; disp_pred_target = 0;
    disp_rs_val = 0; disp_rt_val = 0; disp_rs_tag = 0; disp_rt_tag = 0;
    e_valid = 0;
    @(negedge clk);

    // Reset state
    reset = 1;
    step();
    step();
    idle();
    check("lit_rst_count", count, 0);
    check("lit_rst_res_valid", res_valid, 0);
    check("lit_rst_res_pc", res_pc, 0);
    check("lit_rst_res_target", res_target, 0);
    check("lit_rst_res_link", res_link, 0);
    check("lit_rst_flags", {res_taken, res_mispredict, res_illegal, res_link_we}, 0);

    // beq taken, mispredicted
    disp({6'd4, 5'd1, 5'd2, 16'h0004}, 32'h100, 32'h108, 32'd5, 32'd5, 0, 0);
    step();
    idle();
    step();
    check("lit_beq_valid", res_valid, 1);
    check("lit_beq_target", res_target, 32'h114);
    check("lit_beq_taken", res_taken, 1);
    check("lit_beq_mis", res_mispredict, 1);

    // bne waiting on CDB
    disp({6'd5, 5'd1, 5'd2, 16'h0020}, 32'h200, 32'h208, 32'd0, 32'h55, 3, 0);
    step();
    idle();
    step();
    check("lit_bne_wait1", res_valid, 0);
    cdb_valid = 1; cdb_tag = 3; cdb_data = 32'h55;
    step();
    check("lit_bne_cdb_cycle", res_valid, 0);
    idle();
    step();
    check("lit_bne_valid", res_valid, 1);
    check("lit_bne_target", res_target, 32'h208);
    check("lit_bne_taken", res_taken, 0);
    check("lit_bne_mis", res_mispredict, 0);

    // Fill the station behind a blocked jr
    disp({6'd0, 20'd0, 6'd8}, 32'h1000, 32'h3000, 32'd0, 32'd0, 7, 0);
    step();
    for (int k = 1; k < DEPTH; k++) begin
      disp({6'd2, 26'h40}, 32'h1000 + 32'(4 * k), 32'h100, 32'd0, 32'd0, 0, 0);
      step();
    end
    check("lit_full_count", count, 4);
    #1 check("lit_full_ready", disp_ready, 0);
    step();
    cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h3000;
    step();
    cdb_valid = 0;
    step();
    check("lit_after_pop_count", count, 3);
    check("lit_after_pop_ready", disp_ready, 1);
    check("lit_jr_target", res_target, 32'h3000);
    idle();
    for (int k = 0; k < 4; k++) step();

    // jal mispredict squashes younger dispatch
    disp({6'd3, 26'h10}, 32'h0040_0000, 32'h0040_0008, 0, 0, 0, 0);
    step();
    disp({6'd2, 26'h80}, 32'h0040_0004, 32'h200, 0, 0, 0, 0);
    step();
    check("lit_jal_link", res_link, 32'h0040_0008);
    check("lit_jal_lwe", res_link_we, 1);
    check("lit_jal_target", res_target, 32'h40);
    check("lit_jal_mis", res_mispredict, 1);
    check("lit_jal_count", count, 0);
    idle();
    step();
    check("lit_jal_no_more", res_valid, 0);

    // blez / bgtz signed, illegal opcode
    disp({6'd6, 5'd1, 5'd0, 16'h0010}, 32'h500, 32'h544, 32'h8000_0000, 0, 0, 0);
    step();
    disp({6'd7, 5'd1, 5'd0, 16'h0010}, 32'h600, 32'h608, 32'h0, 0, 0, 0);
    step();
    check("lit_blez_taken", res_taken, 1);
    check("lit_blez_target", res_target, 32'h544);
    idle();
    step();
    check("lit_bgtz_taken", res_taken, 0);
    check("lit_bgtz_target", res_target, 32'h608);
    disp({6'h3F, 26'h0}, 32'h700, 32'h708, 0, 0, 0, 0);
    step();
    idle();
    step();
    check("lit_ill_flag", res_illegal, 1);
    check("lit_ill_mis", res_mispredict, 1);
    check("lit_ill_taken", res_taken, 0);
    check("lit_ill_target", res_target, 32'h708);

    // reset + flush with a ready head
    disp({6'd2, 26'h40}, 32'h800, 32'h100, 0, 0, 0, 0);
    step();
    idle();
    reset = 1; flush = 1;
    step();
    check("lit_rf_valid", res_valid, 0);
    check("lit_rf_count", count, 0);
    idle();
    #1 check("lit_ready_after_reset", disp_ready, 1);
    step();

    // Randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 7) begin
        ri  = rand_inst();
        raw = $urandom;
        rpc = {raw[31:2], 2'b00};
        rs  = rand_val();
        rt  = rand_val();
        ts  = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 3));
        tt  = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, 3));
        case ($urandom_range(0, 3))
          0: pred = rpc + 8;
          1: pred = rpc + 4 + {{14{ri[15]}}, ri[15:0], 2'b00};
          2: pred = {rpc[31:28], ri[25:0], 2'b00};
          default: pred = rs;
        endcase
        disp(ri, rpc, pred, rs, rt, ts, tt);
      end
      if ($urandom_range(0, 1) == 0) begin
        cdb_valid = 1;
        cdb_tag   = TAG_W'($urandom_range(0, 3));
        cdb_data  = rand_val();
      end
      step();
    end

    idle();
    for (int k = 0; k < 4; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
